// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the unified-memory arbiter: FSM state
//               encodings, requester-select encoding and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   // Default bus widths
   localparam int unsigned c_def_addr_w = 16;
   localparam int unsigned c_def_data_w = 16;

   // Arbiter FSM states (3-bit, fixed encoding for legacy tooling)
   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_busy_i = 3'd1;
   localparam logic [2:0] c_st_busy_d = 3'd2;
   localparam logic [2:0] c_st_dump   = 3'd3;
   localparam logic [2:0] c_st_halted = 3'd4;

   // Which requester won the current IDLE arbitration
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_I    = 2'd1,
      SEL_D    = 2'd2
   } req_sel_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch, data, halt and memory-side signals of the
//               unified-memory arbiter. The slave modport is the arbiter's
//               view; the master modport is the pipeline/memory environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = c_def_addr_w,
   parameter int unsigned DATA_W = c_def_data_w
);
   // Instruction fetch requester
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic [DATA_W-1:0] i_rdata;
   logic              i_stall;
   logic              i_err;
   // Data requester
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              d_stall;
   logic              d_err;
   // Halt handling
   logic              halt;
   logic              mem_dump;
   logic              halted;
   // Memory side
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt,
             mem_ready, mem_done, mem_rdata,
      output i_done, i_rdata, i_stall, i_err,
             d_done, d_rdata, d_stall, d_err,
             mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, halted
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, halt,
             mem_ready, mem_done, mem_rdata,
      input  i_done, i_rdata, i_stall, i_err,
             d_done, d_rdata, d_stall, d_err,
             mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, halted
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_timeout_ctr
// Description : Clearable saturating up-counter with terminal-count flag.
//               A clear that coincides with an increment loads 1, so the
//               count equals the number of cycles since the clearing event.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_timeout_ctr #(
   parameter int unsigned MAX = 63
) (
   input  wire logic clk,
   input  wire logic rst,    // asynchronous, active low
   input  wire logic clr,
   input  wire logic inc,
   output logic      tc
);
   localparam int unsigned c_w   = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [c_w-1:0] c_max = c_w'(MAX);

   logic [c_w-1:0] r_count;

   // Count up to MAX and hold there; clear has priority over counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= inc ? c_w'(1) : '0;
      end else if (inc && (r_count != c_max)) begin
         r_count <= r_count + c_w'(1);
      end
   end

   assign tc = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Sequences a single-ported multi-cycle unified memory between
//               instruction fetch (I) and the data port (D). D has priority,
//               misaligned addresses are rejected without issuing, accesses
//               time out after TIMEOUT-1 cycles, and halt drains outstanding
//               D work, pulses mem_dump once and then freezes.
//               Optional macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX
//               consecutive D grants while I waits, I is granted once.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = c_def_addr_w,
   parameter int unsigned DATA_W     = c_def_data_w,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned STARVE_MAX = 4
) (
   input  wire logic     clk,
   input  wire logic     rst,    // asynchronous, active low
   mem_arbiter_if.slave  bus
);
   // Terminal count of the access timer; TIMEOUT below 2 is not meaningful
   localparam int unsigned c_timeout_tc = (TIMEOUT < 2) ? 1 : TIMEOUT - 1;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   req_sel_e          w_sel;
   logic              w_issue;
   logic              w_busy;
   logic              w_timeout;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_sel_wr;

   assign w_busy = (r_state == c_st_busy_i) || (r_state == c_st_busy_d);

   // Access timer: loads 1 on the issue cycle, then counts BUSY cycles
   mem_arbiter_timeout_ctr #(
      .MAX (c_timeout_tc)
   ) u_timeout_ctr (
      .clk (clk),
      .rst (rst),
      .clr (w_issue),
      .inc (w_issue | w_busy),
      .tc  (w_timeout)
   );

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic w_starve_tc;
   logic w_grant_i;
   logic w_grant_d;

   // A grant is any IDLE selection that is served: issued or rejected
   assign w_grant_i = (r_state == c_st_idle) && (w_sel == SEL_I) &&
                      (bus.i_addr[0] || bus.mem_ready);
   assign w_grant_d = (r_state == c_st_idle) && (w_sel == SEL_D) &&
                      (bus.d_addr[0] || bus.mem_ready);

   // Consecutive D grants while I is waiting
   mem_arbiter_timeout_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk (clk),
      .rst (rst),
      .clr (w_grant_i | ~bus.i_req),
      .inc (w_grant_d & bus.i_req),
      .tc  (w_starve_tc)
   );
`else
   localparam int unsigned c_starve_unused = STARVE_MAX;
`endif

   // Arbitration, issue, completion and halt sequencing
   always_comb begin
      w_state_nxt   = r_state;
      w_sel         = SEL_NONE;
      w_issue       = 1'b0;
      w_sel_addr    = '0;
      w_sel_wdata   = '0;
      w_sel_wr      = 1'b0;
      bus.i_done    = 1'b0;
      bus.i_rdata   = '0;
      bus.i_err     = 1'b0;
      bus.d_done    = 1'b0;
      bus.d_rdata   = '0;
      bus.d_err     = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_dump  = 1'b0;
      bus.halted    = 1'b0;

      case (r_state)
         c_st_idle: begin
            // D is the older instruction; halt stops new fetch grants
            if (bus.d_req) begin
               w_sel = SEL_D;
            end else if (bus.i_req && !bus.halt) begin
               w_sel = SEL_I;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (bus.d_req && bus.i_req && !bus.halt && w_starve_tc) begin
               w_sel = SEL_I;
            end
`endif
            if (bus.halt && !bus.d_req) begin
               w_state_nxt = c_st_dump;
            end

            if (w_sel == SEL_D) begin
               w_sel_addr  = bus.d_addr;
               w_sel_wdata = bus.d_wdata;
               w_sel_wr    = bus.d_wr;
            end else if (w_sel == SEL_I) begin
               w_sel_addr  = bus.i_addr;
            end

            if (w_sel != SEL_NONE) begin
               if (w_sel_addr[0]) begin
                  // Misaligned: reject in place, never reaches memory
                  if (w_sel == SEL_D) begin
                     bus.d_done = 1'b1;
                     bus.d_err  = 1'b1;
                  end else begin
                     bus.i_done = 1'b1;
                     bus.i_err  = 1'b1;
                  end
               end else if (bus.mem_ready) begin
                  w_issue       = 1'b1;
                  bus.mem_en    = 1'b1;
                  bus.mem_wr    = w_sel_wr;
                  bus.mem_addr  = w_sel_addr;
                  bus.mem_wdata = w_sel_wdata;
                  w_state_nxt   = (w_sel == SEL_D) ? c_st_busy_d : c_st_busy_i;
               end
            end
         end

         c_st_busy_i: begin
            if (bus.mem_done) begin
               bus.i_done  = 1'b1;
               bus.i_rdata = bus.mem_rdata;
               w_state_nxt = c_st_idle;
            end else if (w_timeout) begin
               bus.i_done  = 1'b1;
               bus.i_err   = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end

         c_st_busy_d: begin
            if (bus.mem_done) begin
               bus.d_done  = 1'b1;
               bus.d_rdata = bus.mem_rdata;
               w_state_nxt = c_st_idle;
            end else if (w_timeout) begin
               bus.d_done  = 1'b1;
               bus.d_err   = 1'b1;
               w_state_nxt = c_st_idle;
            end
         end

         c_st_dump: begin
            bus.mem_dump = 1'b1;
            w_state_nxt  = c_st_halted;
         end

         c_st_halted: begin
            bus.halted = 1'b1;
         end

         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   assign bus.i_stall = bus.i_req & ~bus.i_done;
   assign bus.d_stall = bus.d_req & ~bus.d_done;

   // State register; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

endmodule
`default_nettype wire
